// File: rtl/aes256_pkg.sv
// Shared constants, FSM encoding and helpers for the AES-256 key schedule sequencer.
package aes256_pkg;

  localparam int NK        = 8;
  localparam int NR        = 14;
  localparam int NUM_RK    = 15;
  localparam int NUM_WORDS = 60;

  // GEN produces one round key (four words) per visit
  localparam logic [1:0] GEN_LAST_CNT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OUT0 = 3'd1,
    S_OUT1 = 3'd2,
    S_GEN  = 3'd3,
    S_OUT  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  function automatic logic [31:0] rot_word(input logic [31:0] t);
    return {t[23:0], t[31:24]};
  endfunction

  // Only meaningful for i a multiple of 8 in 8..56
  function automatic logic [3:0] rcon_idx(input logic [5:0] i);
    return {1'b0, i[5:3]} - 4'd1;
  endfunction

endpackage

// File: rtl/aes256_key_word.sv
// Combinational AES-256 next-word unit: w[i] from w[i-8], w[i-1], S-box result and rcon.
module aes256_key_word (
  input  logic [31:0] w_im8_i,
  input  logic [31:0] w_im1_i,
  input  logic [2:0]  i_lo_i,
  input  logic [31:0] sb_out_i,
  input  logic [31:0] rc_val_i,
  output logic [31:0] w_new_o
);

  always_comb begin
    w_new_o = w_im8_i ^ w_im1_i;
    case (i_lo_i)
      3'd0:    w_new_o = w_im8_i ^ sb_out_i ^ rc_val_i;
      3'd4:    w_new_o = w_im8_i ^ sb_out_i;
      default: w_new_o = w_im8_i ^ w_im1_i;
    endcase
  end

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key expansion sequencer: one schedule word per cycle, round keys out on valid/ready.
// Build option KEY_SCHED_ZEROIZE_EN clears the window and rk_data when the schedule completes.
//
// state | meaning
// IDLE  | waiting for start
// OUT0  | presenting rk0 (w0..w3)
// OUT1  | presenting rk1 (w4..w7)
// GEN   | four cycles, one new word per cycle
// OUT   | presenting rk2..rk14, generator stalled
// FIN   | done pulse, busy dropped
module aes256_key_sched_ctrl
  import aes256_pkg::*;
#(
  parameter int NR = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic [3:0]   rc_idx,
  input  logic [31:0]  rc_val,
  output logic [31:0]  sb_in,
  input  logic [31:0]  sb_out,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_data,
  output logic         busy,
  output logic         done
);

  if (NR != aes256_pkg::NR) begin : g_nr_check
    $error("aes256_key_sched_ctrl: NR must be 14");
  end

  localparam logic [3:0] LAST_RK = 4'(aes256_pkg::NR);

  state_t         state_q;
  logic [255:0]   win_q, win_d;
  logic [127:0]   rk_data_q;
  logic [3:0]     rk_idx_q;
  logic           rk_valid_q;
  logic           busy_q;
  logic           done_q;
  logic [5:0]     i_q;
  logic [1:0]     gen_cnt_q;
  logic [31:0]    sb_q;
  logic [3:0]     rc_q;
  logic [31:0]    w_new;

  // Window packed like key_in: oldest word w[i-8] at [255:224], newest w[i-1] at [31:0]
  aes256_key_word u_word (
    .w_im8_i  (win_q[255:224]),
    .w_im1_i  (win_q[31:0]),
    .i_lo_i   (i_q[2:0]),
    .sb_out_i (sb_out),
    .rc_val_i (rc_val),
    .w_new_o  (w_new)
  );

  assign win_d = {win_q[223:0], w_new};

  // S-box and rcon lookups are combinational and external, so their inputs must be valid
  // in the same cycle; the _q copies hold the last value between uses.
  always_comb begin
    sb_in  = sb_q;
    rc_idx = rc_q;
    if (state_q == S_GEN) begin
      if (i_q[2:0] == 3'd0) begin
        sb_in  = rot_word(win_q[31:0]);
        rc_idx = rcon_idx(i_q);
      end else if (i_q[2:0] == 3'd4) begin
        sb_in  = win_q[31:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      win_q      <= '0;
      rk_data_q  <= '0;
      rk_idx_q   <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      i_q        <= '0;
      gen_cnt_q  <= '0;
      sb_q       <= '0;
      rc_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            win_q      <= key_in;
            rk_data_q  <= key_in[255:128];
            rk_idx_q   <= 4'd0;
            rk_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            i_q        <= 6'(NK);
            state_q    <= S_OUT0;
          end
        end
        S_OUT0: begin
          if (rk_ready) begin
            rk_data_q <= win_q[127:0];
            rk_idx_q  <= 4'd1;
            state_q   <= S_OUT1;
          end
        end
        S_OUT1: begin
          if (rk_ready) begin
            rk_valid_q <= 1'b0;
            gen_cnt_q  <= GEN_LAST_CNT;
            state_q    <= S_GEN;
          end
        end
        S_GEN: begin
          win_q <= win_d;
          i_q   <= i_q + 6'd1;
          sb_q  <= sb_in;
          rc_q  <= rc_idx;
          if (gen_cnt_q == 2'd0) begin
            rk_data_q  <= win_d[127:0];
            rk_idx_q   <= rk_idx_q + 4'd1;
            rk_valid_q <= 1'b1;
            state_q    <= S_OUT;
          end else begin
            gen_cnt_q <= gen_cnt_q - 2'd1;
          end
        end
        S_OUT: begin
          if (rk_ready) begin
            rk_valid_q <= 1'b0;
            if (rk_idx_q == LAST_RK) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FIN;
`ifdef KEY_SCHED_ZEROIZE_EN
              win_q     <= '0;
              rk_data_q <= '0;
`endif
            end else begin
              gen_cnt_q <= GEN_LAST_CNT;
              state_q   <= S_GEN;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rk_valid = rk_valid_q;
  assign rk_idx   = rk_idx_q;
  assign rk_data  = rk_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Directed bench for aes256_key_sched_ctrl: FIPS-197 A.3 vectors, timing, backpressure, reset abort.
module tb_aes256_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] key_in = '0;
  logic [3:0]   rc_idx;
  logic [31:0]  rc_val;
  logic [31:0]  sb_in;
  logic [31:0]  sb_out;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         busy;
  logic         done;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [255:0] KEY_A = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_B = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RK0   = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] RK1   = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK2   = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] RK14  = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] RKZ2  = 128'h62636363626363636263636362636363;

  logic [7:0]   sbox   [256];
  logic [31:0]  exp_w  [60];
  logic [127:0] rk_log [15];
  int           rk_cyc [15];
  int           done_cyc;
  logic [3:0]   rc_log [128];
  logic [31:0]  sb_log [128];
  logic [127:0] fin_exp;

  aes256_key_sched_ctrl #(.NR(14)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .rc_idx   (rc_idx),
    .rc_val   (rc_val),
    .sb_in    (sb_in),
    .sb_out   (sb_out),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_idx   (rk_idx),
    .rk_data  (rk_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rcon_word(input logic [3:0] k);
    case (k)
      4'd0:    return 32'h01000000;
      4'd1:    return 32'h02000000;
      4'd2:    return 32'h04000000;
      4'd3:    return 32'h08000000;
      4'd4:    return 32'h10000000;
      4'd5:    return 32'h20000000;
      4'd6:    return 32'h40000000;
      default: return 32'h00000000;
    endcase
  endfunction

  // External lookups the DUT shares with the cipher round
  assign rc_val = rcon_word(rc_idx);
  assign sb_out = {sbox[sb_in[31:24]], sbox[sb_in[23:16]], sbox[sb_in[15:8]], sbox[sb_in[7:0]]};

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    for (int k = 0; k < 254; k++) r = gmul(r, x);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key);
    logic [31:0] t;
    for (int i = 0; i < 8; i++) exp_w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = exp_w[i-1];
      if (i % 8 == 0)      t = subw({t[23:0], t[31:24]}) ^ rcon_word(4'(i/8 - 1));
      else if (i % 8 == 4) t = subw(t);
      exp_w[i] = exp_w[i-8] ^ t;
    end
  endtask

  function automatic logic [127:0] rk_exp(input int k);
    return {exp_w[4*k], exp_w[4*k+1], exp_w[4*k+2], exp_w[4*k+3]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an expansion and checks every presented round key against the model.
  task automatic run_stream(input logic [255:0] key, input int stall_k, input int stall_len,
                            input int restart_cyc, input logic [255:0] key2);
    int           cyc;
    int           exp_k;
    int           stall_left;
    bit           prev_stalled;
    bit           seen_done;
    logic [127:0] prev_data;
    logic [3:0]   prev_idx;
    expand(key);
`ifdef KEY_SCHED_ZEROIZE_EN
    fin_exp = '0;
`else
    fin_exp = rk_exp(14);
`endif
    for (int k = 0; k < 15; k++) begin
      rk_log[k] = 'x;
      rk_cyc[k] = -1;
    end
    done_cyc     = -1;
    key_in       = key;
    start        = 1'b1;
    rk_ready     = 1'b1;
    tick();
    start        = 1'b0;
    cyc          = 1;
    exp_k        = 0;
    stall_left   = stall_len;
    prev_stalled = 1'b0;
    seen_done    = 1'b0;
    prev_data    = '0;
    prev_idx     = '0;
    while (!seen_done && cyc < 400) begin
      if (cyc < 128) begin
        rc_log[cyc] = rc_idx;
        sb_log[cyc] = sb_in;
      end
      if (prev_stalled) begin
        chk("stall_valid", 128'(rk_valid), 128'(1));
        chk("stall_idx", 128'(rk_idx), 128'(prev_idx));
        chk("stall_data", rk_data, prev_data);
      end
      if (rk_valid) begin
        chk("rk_idx", 128'(rk_idx), 128'(exp_k));
        if (exp_k < 15) chk("rk_data", rk_data, rk_exp(exp_k));
        else chk("extra_rk", 128'(1), 128'(0));
      end
      if (done) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
        chk("keys_before_done", 128'(exp_k), 128'(15));
        chk("fin_busy", 128'(busy), 128'(0));
        chk("fin_valid", 128'(rk_valid), 128'(0));
        chk("fin_rk_data", rk_data, fin_exp);
      end
      if (cyc == restart_cyc) begin
        start  = 1'b1;
        key_in = key2;
      end else begin
        start  = 1'b0;
      end
      if (rk_valid && exp_k == stall_k && stall_left > 0) begin
        rk_ready = 1'b0;
        stall_left--;
      end else begin
        rk_ready = 1'b1;
      end
      prev_stalled = rk_valid && !rk_ready;
      prev_data    = rk_data;
      prev_idx     = rk_idx;
      if (rk_valid && rk_ready && exp_k < 15) begin
        rk_log[exp_k] = rk_data;
        rk_cyc[exp_k] = cyc;
      end
      if (rk_valid && rk_ready) exp_k++;
      tick();
      cyc++;
    end
    if (!seen_done) chk("done_timeout", 128'(0), 128'(1));
    start    = 1'b0;
    rk_ready = 1'b1;
  endtask

  initial begin
    for (int x = 0; x < 256; x++) sbox[x] = sbox_calc(8'(x));

    // Power-on reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 128'(rk_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_idx", 128'(rk_idx), 128'(0));
    chk("rst_data", rk_data, 128'(0));
    chk("rst_rc_idx", 128'(rc_idx), 128'(0));
    chk("rst_sb_in", 128'(sb_in), 128'(0));
    rst = 1'b0;
    tick();

    // FIPS-197 A.3 key, consumer always ready
    run_stream(KEY_A, -1, 0, -1, '0);
    chk("a3_rk0", rk_log[0], RK0);
    chk("a3_rk1", rk_log[1], RK1);
    chk("a3_rk2", rk_log[2], RK2);
    chk("a3_rk14", rk_log[14], RK14);
    chk("lat_rk0", 128'(rk_cyc[0]), 128'(1));
    chk("lat_rk1", 128'(rk_cyc[1]), 128'(2));
    chk("lat_rk2", 128'(rk_cyc[2]), 128'(7));
    chk("lat_rk3", 128'(rk_cyc[3]), 128'(12));
    chk("lat_rk14", 128'(rk_cyc[14]), 128'(67));
    chk("lat_done", 128'(done_cyc), 128'(68));
    chk("w8_rc_idx", 128'(rc_log[3]), 128'(0));
    chk("w8_sb_in", 128'(sb_log[3]), 128'(32'h14dff409));
    chk("w9_rc_hold", 128'(rc_log[4]), 128'(0));
    chk("w12_sb_in", 128'(sb_log[8]), 128'(32'h2067fcde));
    chk("w56_rc_idx", 128'(rc_log[63]), 128'(6));
    chk("idle_done", 128'(done), 128'(0));
    chk("idle_valid", 128'(rk_valid), 128'(0));
    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_rk_data", rk_data, fin_exp);

    // Backpressure on rk5 for 10 cycles, and a second start at cycle 20 that must be ignored
    run_stream(KEY_A, 5, 10, 20, KEY_B);
    chk("bp_rk5_cyc", 128'(rk_cyc[5]), 128'(32));
    chk("bp_rk6", rk_log[6], rk_exp(6));
    chk("bp_rk14", rk_log[14], RK14);
    chk("bp_done", 128'(done_cyc), 128'(78));

    // Reset at cycle 30 aborts; next start with all-zero key runs fresh
    key_in = KEY_A;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int c = 1; c < 30; c++) tick();
    rst = 1'b1;
    #1;
    chk("abort_valid", 128'(rk_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_idx", 128'(rk_idx), 128'(0));
    chk("abort_data", rk_data, 128'(0));
    tick();
    rst = 1'b0;
    tick();
    run_stream(256'h0, -1, 0, -1, '0);
    chk("zero_rk0", rk_log[0], 128'(0));
    chk("zero_rk2", rk_log[2], RKZ2);
    chk("zero_done", 128'(done_cyc), 128'(68));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes256_key_sched_ctrl.md
Name: aes256_key_sched_ctrl

Overview:
Sequencer for AES-256 key expansion (FIPS-197, Nk=8, Nr=14).
- Captures a 256-bit cipher key and produces the 60-word schedule one word per cycle.
- Drives the rcon lookup index and a shared external S-box port.
- Emits the 15 round keys of 128 bits in order over a valid/ready stream to the round datapath.

Parameters:
NR, 14, number of rounds. 14 is the only legal value; any other value fails an elaboration-time check.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request to begin expansion; honoured only in IDLE
key_in  in  256  cipher key; [255:224]=w0 … [31:0]=w7; sampled on the accepted start
rc_idx  out  4  index to the rcon lookup; value is i/8-1 for word i
rc_val  in  32  rcon word from the lookup (Rcon byte in [31:24]); combinational, same cycle
sb_in  out  32  word presented to the external 4-lane S-box
sb_out  in  32  SubWord(sb_in); combinational, same cycle
rk_valid  out  1  round key available
rk_ready  in  1  consumer accepts the round key
rk_idx  out  4  round key number, 0..14
rk_data  out  128  round key; words w[4k]..w[4k+3], MSB first
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse after round key 14 is accepted

Behaviour:
- Reset is asynchronous. On rst high: state=IDLE, window=0, rk_valid=0, rk_idx=0, rk_data=0, busy=0, done=0, rc_idx=0, sb_in=0, word counter i=0.
- Window is an 8×32 shift register holding w[i-8..i-1]. rk_data is the last four words of the window.
- States:
  - IDLE: start=1 loads the window with key_in, sets busy=1, rk_idx=0 and i=8, and moves to OUT0.
  - OUT0: presents rk_valid=1 with rk_data = w0..w3. On handshake, moves to OUT1.
  - OUT1: presents w4..w7 with rk_idx=1. On handshake, moves to GEN.
  - GEN: runs exactly 4 cycles, computing one word per cycle; increments i and shifts the window. Afterwards moves to OUT with rk_idx incremented.
  - OUT: rk_valid=1. On handshake, moves to GEN if rk_idx<14. If rk_idx=14, moves to FIN.
  - FIN: done=1 for one cycle, busy=0, then IDLE.
- Word rule in GEN, with t=w[i-1]:
  - i%8==0: w[i] = w[i-8] ^ SubWord(RotWord(t)) ^ rc_val; sb_in=RotWord(t); rc_idx=i/8-1 (range 0..6).
  - i%8==4: w[i] = w[i-8] ^ SubWord(t); sb_in=t.
  - otherwise: w[i] = w[i-8] ^ t; sb_in holds its previous value; rc_idx holds.
- RotWord(t) = {t[23:0], t[31:24]}.
- rk_data, rk_idx and rk_valid are stable while rk_valid=1 and rk_ready=0. The generator stalls in OUT; no word is overwritten.
- Latency with rk_ready tied high:
  - start accepted at cycle 0;
  - rk0 at cycle 1, rk1 at cycle 2;
  - rk k (k≥2) at cycle 7+5(k-2), so rk14 at cycle 67;
  - done at cycle 68.
- start while busy is ignored; key_in is not resampled.
- rk_ready outside OUT0/OUT1/OUT is ignored.
- Reset asserted mid-operation aborts immediately. The next start begins a fresh expansion.

Optional Feature:
Macro KEY_SCHED_ZEROIZE_EN.
- Defined: in FIN, the window and rk_data are cleared to 0 in the same cycle as done. No key material remains after completion.
- Undefined: window and rk_data retain w52..w59 / rk14 until the next start or reset.
- In both cases rk_valid=0 in FIN and IDLE.

Decomposition:
Shared package aes256_pkg holds:
- constants NK=8, NR=14, NUM_RK=15, NUM_WORDS=60;
- the state encoding (IDLE, OUT0, OUT1, GEN, OUT, FIN);
- functions rot_word and the rcon index calculation.

One sub-module is natural: aes256_key_word, the combinational next-word unit. Inputs are w[i-8], w[i-1], i[2:0], sb_out and rc_val; output is w[i].
The rcon lookup and the S-box stay external, so they can be shared with the cipher round.

Test Plan:
- FIPS-197 A.3 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, rk_ready=1 -> rk0=603deb1015ca71be2b73aef0857d7781 at cycle 1; rk2=9ba354118e6925afa51a8b5f2067fcde at cycle 7; rc_idx=0 during the w8 cycle.
- Same key -> rk14=fe4890d1e6188d0b046df344706c631e at cycle 67; done at 68; busy low at 68; rc_idx reaches 6 at w56.
- Backpressure: rk_ready=0 for 10 cycles while rk5 is valid -> rk_data/rk_idx stable; rk6 is correct after release; total schedule matches the reference vectors.
- start pulsed again at cycle 20 with a different key -> ignored; the original schedule completes unchanged.
- rst asserted at cycle 30, then start with an all-zero key -> rk2=62636363626363636263636362636363.
- With KEY_SCHED_ZEROIZE_EN -> rk_data=0 from FIN onward. Without it -> rk_data holds rk14.
